// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, halt word default and fetch FSM states.
package cpu_pkg;

  localparam int unsigned COND_MSB   = 31;
  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned OPCODE_MSB = 27;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned S_BIT      = 23;
  localparam int unsigned DEST_MSB   = 22;
  localparam int unsigned DEST_LSB   = 19;
  localparam int unsigned SRC2_MSB   = 18;
  localparam int unsigned SRC2_LSB   = 15;
  localparam int unsigned SRC1_MSB   = 14;
  localparam int unsigned SRC1_LSB   = 11;
  localparam int unsigned SHIFT_MSB  = 10;
  localparam int unsigned SHIFT_LSB  = 6;
  localparam int unsigned IVMOV_MSB  = 18;
  localparam int unsigned IVMOV_LSB  = 3;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StValid,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, +1 with natural wrap, and a load port that wins over increment.
module pc_reg #(
  parameter int unsigned        AddrW   = 16,
  parameter logic [AddrW-1:0]   ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_addr_i,
  output logic [AddrW-1:0] pc_o
);

  logic [AddrW-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, RAM read sequencing, instruction register and valid/ready output.
// Optional FETCH_COUNT_EN adds a saturating Fetch_count of accepted instructions.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 16,
  parameter int unsigned         DATA_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter int unsigned         RD_LAT    = 1,
  parameter logic [DATA_W-1:0]   HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Enable,
  output logic              RW_ram,
  output logic [ADDR_W-1:0] Address_in,
  input  logic [DATA_W-1:0] Out,
  input  logic              Mem_busy,
  input  logic              Redirect_valid,
  input  logic [ADDR_W-1:0] Redirect_addr,
  input  logic              Instr_ready,
  output logic              Instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        Cond,
  output logic [3:0]        OpCode,
  output logic              S,
  output logic [3:0]        destination,
  output logic [3:0]        source_2,
  output logic [3:0]        source_1,
  output logic [4:0]        IV_ShiftRor,
  output logic [15:0]       IV_Mov,
  output logic              Halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       Fetch_count
`endif
);

  localparam logic [2:0] LatInit = 3'(RD_LAT - 1);

  fetch_state_e      state_q;
  logic              en_q, valid_q, halted_q;
  logic [ADDR_W-1:0] addr_q, pc_q, pc_cur;
  logic [DATA_W-1:0] instr_q;
  logic [2:0]        cnt_q;
  logic              pc_inc, pc_load;

  // A redirect coinciding with acceptance overrides the increment inside pc_reg.
  assign pc_load = Redirect_valid;
  assign pc_inc  = (state_q == StValid) && Instr_ready;

  pc_reg #(
    .AddrW   (ADDR_W),
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .inc_i       (pc_inc),
    .load_i      (pc_load),
    .load_addr_i (Redirect_addr),
    .pc_o        (pc_cur)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StReq;
      en_q     <= 1'b0;
      addr_q   <= RESET_PC;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else if (Redirect_valid) begin
      state_q  <= StReq;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (Mem_busy) begin
            en_q <= 1'b0;
          end else begin
            en_q    <= 1'b1;
            addr_q  <= pc_cur;
            cnt_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (Mem_busy) begin
            // Data-memory traffic steals the RAM; retry the same PC later.
            en_q    <= 1'b0;
            state_q <= StReq;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 3'd1;
          end else if (Out == HALT_WORD) begin
            en_q     <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            en_q    <= 1'b0;
            instr_q <= Out;
            pc_q    <= pc_cur;
            valid_q <= 1'b1;
            state_q <= StValid;
          end
        end
        StValid: begin
          if (Instr_ready) begin
            valid_q <= 1'b0;
            state_q <= StReq;
          end
        end
        StHalt: begin
          en_q <= 1'b0;
        end
        default: state_q <= StReq;
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fcnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fcnt_q <= '0;
    end else if (valid_q && Instr_ready && (fcnt_q != 32'hFFFF_FFFF)) begin
      fcnt_q <= fcnt_q + 32'd1;
    end
  end

  assign Fetch_count = fcnt_q;
`endif

  assign Enable      = en_q;
  assign RW_ram      = 1'b1;
  assign Address_in  = addr_q;
  assign Instr_valid = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign Halted      = halted_q;

  assign Cond        = instr_q[COND_MSB:COND_LSB];
  assign OpCode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign S           = instr_q[S_BIT];
  assign destination = instr_q[DEST_MSB:DEST_LSB];
  assign source_2    = instr_q[SRC2_MSB:SRC2_LSB];
  assign source_1    = instr_q[SRC1_MSB:SRC1_LSB];
  assign IV_ShiftRor = instr_q[SHIFT_MSB:SHIFT_LSB];
  assign IV_Mov      = instr_q[IVMOV_MSB:IVMOV_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a single-cycle combinational RAM model (RD_LAT=1).
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable, RW_ram;
  logic [15:0] Address_in;
  logic [31:0] Out;
  logic        Mem_busy, Redirect_valid, Instr_ready;
  logic [15:0] Redirect_addr;
  logic        Instr_valid;
  logic [31:0] instruction;
  logic [15:0] pc;
  logic [3:0]  Cond, OpCode, destination, source_2, source_1;
  logic        S;
  logic [4:0]  IV_ShiftRor;
  logic [15:0] IV_Mov;
  logic        Halted;
`ifdef FETCH_COUNT_EN
  logic [31:0] Fetch_count;
`endif

  logic [31:0] mem [0:65535];
  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int bad;
  int seen;

  always #5 Clk = ~Clk;

  assign Out = Enable ? mem[Address_in] : 32'h0;

  instr_fetch_unit dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (Enable),
    .RW_ram         (RW_ram),
    .Address_in     (Address_in),
    .Out            (Out),
    .Mem_busy       (Mem_busy),
    .Redirect_valid (Redirect_valid),
    .Redirect_addr  (Redirect_addr),
    .Instr_ready    (Instr_ready),
    .Instr_valid    (Instr_valid),
    .instruction    (instruction),
    .pc             (pc),
    .Cond           (Cond),
    .OpCode         (OpCode),
    .S              (S),
    .destination    (destination),
    .source_2       (source_2),
    .source_1       (source_1),
    .IV_ShiftRor    (IV_ShiftRor),
    .IV_Mov         (IV_Mov),
    .Halted         (Halted)
`ifdef FETCH_COUNT_EN
    ,
    .Fetch_count    (Fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step negedges until a word is offered (bounded), then check it.
  task automatic expect_word(input string tag, input logic [31:0] exp_w, input logic [15:0] exp_pc,
                             output int cycles);
    cycles = 0;
    do begin
      @(negedge Clk);
      cycles++;
    end while (!Instr_valid && cycles < 50);
    check({tag, " valid"}, 64'(Instr_valid), 64'd1);
    check({tag, " instr"}, 64'(instruction), 64'(exp_w));
    check({tag, " pc"}, 64'(pc), 64'(exp_pc));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[0]      = 32'h1111_1111;
    mem[1]      = 32'h2222_2222;
    mem[2]      = 32'h3333_3333;
    mem[3]      = 32'h4444_4444;
    mem[4]      = 32'h5555_5555;
    mem[5]      = 32'hFFFF_FFFF;
    mem[16'h40] = 32'hA5C3_9E71;
    mem[16'hFFFF] = 32'hCAFE_F00D;

    Reset = 1'b1; Mem_busy = 1'b0; Redirect_valid = 1'b0; Redirect_addr = '0; Instr_ready = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst Enable", 64'(Enable), 64'd0);
    check("rst RW_ram", 64'(RW_ram), 64'd1);
    check("rst Address_in", 64'(Address_in), 64'd0);
    check("rst Instr_valid", 64'(Instr_valid), 64'd0);
    check("rst instruction", 64'(instruction), 64'd0);
    check("rst pc", 64'(pc), 64'd0);
    check("rst Halted", 64'(Halted), 64'd0);
`ifdef FETCH_COUNT_EN
    check("rst Fetch_count", 64'(Fetch_count), 64'd0);
`endif

    // Streaming fetch of words 0..3 with ready held high.
    Reset = 1'b0;
    expect_word("w0", 32'h1111_1111, 16'd0, lat);
    check("w0 latency", 64'(lat), 64'd2);
    check("w0 OpCode", 64'(OpCode), 64'h1);
    check("w0 Enable", 64'(Enable), 64'd0);
    expect_word("w1", 32'h2222_2222, 16'd1, lat);
    check("w1 spacing", 64'(lat), 64'd3);
    expect_word("w2", 32'h3333_3333, 16'd2, lat);
    check("w2 spacing", 64'(lat), 64'd3);
    expect_word("w3", 32'h4444_4444, 16'd3, lat);
    check("w3 spacing", 64'(lat), 64'd3);

    // Backpressure: word 3 must hold for 5 cycles with RAM idle.
    Instr_ready = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Instr_valid !== 1'b1 || instruction !== 32'h4444_4444 || pc !== 16'd3 ||
          OpCode !== 4'h4 || Enable !== 1'b0) bad++;
    end
    check("hold stable cycles bad", 64'(bad), 64'd0);
    Instr_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("after hold Enable", 64'(Enable), 64'd1);
    check("after hold Address_in", 64'(Address_in), 64'd4);
    expect_word("w4", 32'h5555_5555, 16'd4, lat);

    // Halt word at address 5 is never delivered.
    seen = 0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (Instr_valid) seen++;
    end while (!Halted && lat < 10);
    check("halt Halted", 64'(Halted), 64'd1);
    check("halt lat", 64'(lat), 64'd3);
    check("halt no valid", 64'(seen), 64'd0);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Enable !== 1'b0 || Instr_valid !== 1'b0 || Halted !== 1'b1) bad++;
    end
    check("halt idle cycles bad", 64'(bad), 64'd0);
    check("halt instr held", 64'(instruction), 64'h5555_5555);
    Redirect_valid = 1'b1; Redirect_addr = 16'h0000;
    @(negedge Clk);
    Redirect_valid = 1'b0;
    check("unhalt Halted", 64'(Halted), 64'd0);
    expect_word("refetch w0", 32'h1111_1111, 16'd0, lat);
    check("refetch w0 latency", 64'(lat), 64'd2);
    expect_word("refetch w1", 32'h2222_2222, 16'd1, lat);

    // Mem_busy steals the RAM during the WAIT of address 2.
    @(negedge Clk);
    @(negedge Clk);
    check("busy pre Enable", 64'(Enable), 64'd1);
    check("busy pre Address_in", 64'(Address_in), 64'd2);
    Mem_busy = 1'b1;
    @(negedge Clk);
    check("busy abort Enable", 64'(Enable), 64'd0);
    check("busy abort valid", 64'(Instr_valid), 64'd0);
    bad = 0;
    repeat (2) begin
      @(negedge Clk);
      if (Enable !== 1'b0 || Instr_valid !== 1'b0) bad++;
    end
    check("busy idle cycles bad", 64'(bad), 64'd0);
    Mem_busy = 1'b0;
    expect_word("retry w2", 32'h3333_3333, 16'd2, lat);
    expect_word("after retry w3", 32'h4444_4444, 16'd3, lat);
    check("after retry spacing", 64'(lat), 64'd3);

    // Redirect coincident with acceptance of word 3.
    Redirect_valid = 1'b1; Redirect_addr = 16'h0040;
    @(negedge Clk);
    Redirect_valid = 1'b0;
    Instr_ready = 1'b0;
    check("redir valid drop", 64'(Instr_valid), 64'd0);
    @(negedge Clk);
    check("redir Address_in", 64'(Address_in), 64'h40);
    check("redir Enable", 64'(Enable), 64'd1);
`ifdef FETCH_COUNT_EN
    check("redir Fetch_count", 64'(Fetch_count), 64'd9);
`endif
    expect_word("w40", 32'hA5C3_9E71, 16'h0040, lat);
    check("f Cond", 64'(Cond), 64'hA);
    check("f OpCode", 64'(OpCode), 64'h5);
    check("f S", 64'(S), 64'd1);
    check("f destination", 64'(destination), 64'h8);
    check("f source_2", 64'(source_2), 64'h7);
    check("f source_1", 64'(source_1), 64'h3);
    check("f IV_ShiftRor", 64'(IV_ShiftRor), 64'h19);
    check("f IV_Mov", 64'(IV_Mov), 64'h73CE);

    // PC wrap from 16'hFFFF.
    Redirect_valid = 1'b1; Redirect_addr = 16'hFFFF;
    @(negedge Clk);
    Redirect_valid = 1'b0;
    expect_word("wFFFF", 32'hCAFE_F00D, 16'hFFFF, lat);
`ifdef FETCH_COUNT_EN
    check("no-ready redir Fetch_count", 64'(Fetch_count), 64'd9);
`endif
    Instr_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("wrap Address_in", 64'(Address_in), 64'd0);
    check("wrap Enable", 64'(Enable), 64'd1);
    expect_word("wrap w0", 32'h1111_1111, 16'd0, lat);

    // Asynchronous reset in the middle of the WAIT for address 1.
    @(negedge Clk);
    @(negedge Clk);
    check("pre-rst Address_in", 64'(Address_in), 64'd1);
    Reset = 1'b1;
    #1;
    check("async rst Enable", 64'(Enable), 64'd0);
    check("async rst Address_in", 64'(Address_in), 64'd0);
    check("async rst instruction", 64'(instruction), 64'd0);
    check("async rst Instr_valid", 64'(Instr_valid), 64'd0);
    check("async rst Halted", 64'(Halted), 64'd0);
`ifdef FETCH_COUNT_EN
    check("async rst Fetch_count", 64'(Fetch_count), 64'd0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    expect_word("post-rst w0", 32'h1111_1111, 16'd0, lat);
    check("post-rst latency", 64'(lat), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
